scsi_burst_adaptor: RTL and testbench
=====================================

SCSI_BURST_ADAPTOR -- requirements
Module: scsi_burst_adaptor

Interface
REQ-001 Parameter BASE_ADDR, 8'h40, register block base within page &FC (decodes BASE_ADDR..BASE_ADDR+4).
REQ-002 Parameter FIFO_DEPTH, 16, data FIFO entries; power of 2, range 4..64.
REQ-003 Parameter ACK_HOLD, 2, minimum sys_CLK cycles ACK stays asserted per burst byte; range 1..15.
REQ-004 Ports, clock and reset first:
- sys_CLK, in, 1, sole clock.
- bbc_nRST, in, 1, synchronous, active-low reset.
- bbc_1MHZE, in, 1, async bus strobe.
- bbc_nPGFC, in, 1, page &FC select, low active.
- bbc_RnW, in, 1, host read high.
- bbc_ADDRESS, in, 8, host address low byte.
- bbc_DATA_in, in, 8, host write data.
- bbc_DATA_out, out, 8, host read data.
- bbc_DATA_oe, out, 1, drive host bus.
- bbc_IRQ_drv, out, 1, pull nIRQ low.
- scsi_nMSG / scsi_nBSY / scsi_nREQ / scsi_InO / scsi_CnD, in, 1 each, target signals.
- scsi_nDATA_in, in, 8, SCSI bus, active low.
- scsi_DATA_drv, out, 8, per-bit pull-low enable.
- scsi_SEL_drv / scsi_ACK_drv / scsi_RST_drv, out, 1 each, pull-low enables.

Function
REQ-005 All async inputs (bbc_1MHZE, bbc_nPGFC, bbc_RnW, bbc_ADDRESS, scsi_n*, scsi_InO, scsi_CnD) SHALL pass a 2-flop synchroniser; the bus access commits on the synchronised bbc_1MHZE falling edge while selected.
- Write data captured on that edge.
- bbc_DATA_oe combinational: selected & RnW & 1MHZE high & decoded read register.
REQ-006 Registers (offset from BASE_ADDR):
- +0 R: data.
- +0 W: data.
- +1 R: status.
- +2 W: assert SEL.
- +3 W: control, bit0 IRQEN, bit1 BURST.
- +4 R: FIFO count, zero-extended.
REQ-007 Status byte SHALL be {~CnD, ~InO, ~nREQ, IRQ, FULL, EMPTY, ~nBSY, ~nMSG}, MSB first.
REQ-008 Legacy mode (BURST=0):
- +0 read returns ~scsi_nDATA_in.
- +0 write latches data; scsi_DATA_drv = latch when scsi_InO=1, else 0.
- Commit of +0 read or write sets ACK; ACK clears one cycle after synchronised REQ deasserts.
REQ-009 SEL SHALL set on a +2 write and clear when synchronised nBSY is low or on reset.
REQ-010 Burst FSM SHALL have states IDLE, WAIT_REQ, ACK, WAIT_NREQ.
- IDLE->WAIT_REQ: BURST=1 & nBSY low & CnD=1 & nMSG=1.
- WAIT_REQ->ACK on REQ asserted, provided:
  - inbound (InO=0): FIFO not full; the byte is pushed on entry.
  - outbound (InO=1): FIFO not empty; the byte is popped and driven.
- ACK->WAIT_NREQ after ACK_HOLD cycles; ACK asserted throughout ACK and WAIT_NREQ.
- WAIT_NREQ->IDLE on REQ deasserted; ACK drops the same cycle.
REQ-011 In BURST mode:
- +0 read pops the FIFO and returns its head.
- +0 write pushes the FIFO.
- Read when empty returns 8'h00 with no pointer change.
- Write when full is discarded.
REQ-012 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; count = wr-rd.
REQ-013 Simultaneous host pop and FSM push in one cycle SHALL both occur, leaving count unchanged.
REQ-014 FSM abort: nBSY deasserting, or a phase change (CnD/InO/nMSG) in any non-IDLE state, SHALL force IDLE and release ACK next cycle; FIFO contents are retained.
REQ-015 Clearing BURST mid-transfer SHALL complete the current byte handshake, then return to IDLE; BURST=0 also flushes the FIFO.
REQ-016 IRQ SHALL set when IRQEN=1 and synchronised REQ rises while FSM is IDLE. It clears on a +3 write or reset; bbc_IRQ_drv = IRQ.
REQ-017 scsi_RST_drv SHALL equal ~bbc_nRST, combinational.

Reset
REQ-018 On bbc_nRST low at a sys_CLK edge:
- FSM IDLE, FIFO empty, control=0, IRQ=0, SEL=0, ACK=0, data latch=8'hFF.
- Outputs: scsi_DATA_drv=0, bbc_DATA_oe=0, bbc_IRQ_drv=0, scsi_RST_drv=1.
REQ-019 Reset mid-handshake SHALL drop ACK on the same edge; no FIFO push completes.

Configuration
REQ-020 With SCSI_FIFO_IRQ_EN defined, control bit2 (FIFOIRQ) is added. When set, IRQ also sets on:
- inbound count reaching FIFO_DEPTH/2;
- outbound FIFO becoming empty.
Without the macro, bit2 reads 0, writes are ignored, and no such logic is present.

Verification
REQ-021 Legacy: write 8'hA5 to &FC40 with InO=1 -> scsi_DATA_drv=8'hA5, ACK set; REQ deassert -> ACK clears.
REQ-022 Burst inbound: BURST=1, target sends 16 bytes 0..15 -> FULL=1, count=16, 17th REQ stalls in WAIT_REQ; host reads return 0..15 in order.
REQ-023 ACK_HOLD=3: ACK low-pulse lasts >=3 sys_CLK cycles plus REQ release time, per byte.
REQ-024 nBSY deasserted in ACK state -> FSM IDLE, ACK released next cycle, count unchanged.
REQ-025 IRQEN=1, REQ rises while IDLE -> bbc_IRQ_drv=1, status bit4=1; write &FC43 -> IRQ cleared.

Source files
------------

// File: rtl/scsi_burst_adaptor.sv
// Host 1MHz-bus register block driving a SCSI target, with legacy single-byte and FIFO burst handshakes.
// Optional FIFO-level interrupts (control bit2) are built only when SCSI_FIFO_IRQ_EN is defined.
module scsi_burst_adaptor #(
    parameter logic [7:0] BASE_ADDR  = 8'h40,
    parameter int         FIFO_DEPTH = 16,
    parameter int         ACK_HOLD   = 2
) (
    input  logic       sys_CLK,
    input  logic       bbc_nRST,
    input  logic       bbc_1MHZE,
    input  logic       bbc_nPGFC,
    input  logic       bbc_RnW,
    input  logic [7:0] bbc_ADDRESS,
    input  logic [7:0] bbc_DATA_in,
    output logic [7:0] bbc_DATA_out,
    output logic       bbc_DATA_oe,
    output logic       bbc_IRQ_drv,
    input  logic       scsi_nMSG,
    input  logic       scsi_nBSY,
    input  logic       scsi_nREQ,
    input  logic       scsi_InO,
    input  logic       scsi_CnD,
    input  logic [7:0] scsi_nDATA_in,
    output logic [7:0] scsi_DATA_drv,
    output logic       scsi_SEL_drv,
    output logic       scsi_ACK_drv,
    output logic       scsi_RST_drv
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = 24;
`ifdef SCSI_FIFO_IRQ_EN
    localparam int CW = 3;
`else
    localparam int CW = 2;
`endif
    localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);
    localparam logic [3:0]    HOLD_LAST = 4'(ACK_HOLD - 1);
    // Synchroniser idle values match an idle bus so reset does not fake edges.
    localparam logic [SW-1:0] SYNC_IDLE = {1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};

    typedef enum logic [1:0] {IDLE, WAIT_REQ, ACK, WAIT_NREQ} state_t;

    logic [SW-1:0] sync1_q, sync2_q, sync1_d;
    logic          e_s, npgfc_s, rnw_s, nmsg_s, nbsy_s, nreq_s, ino_s, cnd_s;
    logic [7:0]    addr_s, ndata_s;

    state_t        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic          ino_ph_q, ino_ph_d;
    logic          e_prev_q, nreq_prev_q;
    logic          ack_q, ack_d, sel_q, sel_d, irq_q, irq_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic [7:0]    latch_q, latch_d, out_q, out_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, count;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic [7:0] offs, head, push_data, status;
    logic       hit, commit, rd0, wr0, wr2, wr3, rd_reg;
    logic       burst, full, empty, abort, flush;
    logic       fsm_push, fsm_pop, host_push, host_pop, push, pop, irq_set;

    assign sync1_d = {bbc_1MHZE, bbc_nPGFC, bbc_RnW, bbc_ADDRESS,
                      scsi_nMSG, scsi_nBSY, scsi_nREQ, scsi_InO, scsi_CnD, scsi_nDATA_in};
    assign {e_s, npgfc_s, rnw_s, addr_s, nmsg_s, nbsy_s, nreq_s, ino_s, cnd_s, ndata_s} = sync2_q;

    // Offsets below BASE_ADDR wrap to large values and fall outside the window.
    assign offs   = addr_s - BASE_ADDR;
    assign hit    = !npgfc_s && (offs <= 8'd4);
    assign commit = hit && e_prev_q && !e_s;
    assign rd0    = commit && rnw_s && (offs == 8'd0);
    assign wr0    = commit && !rnw_s && (offs == 8'd0);
    assign wr2    = commit && !rnw_s && (offs == 8'd2);
    assign wr3    = commit && !rnw_s && (offs == 8'd3);
    assign rd_reg = hit && rnw_s && ((offs == 8'd0) || (offs == 8'd1) || (offs == 8'd4));

    assign burst = ctrl_q[1];
    assign count = wr_q - rd_q;
    assign full  = (count == DEPTH_P);
    assign empty = (wr_q == rd_q);
    assign head  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ino_ph_d = ino_ph_q;
        fsm_push = 1'b0;
        fsm_pop  = 1'b0;
        abort    = (state_q != IDLE) && (nbsy_s || !cnd_s || !nmsg_s || (ino_s != ino_ph_q));
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (burst && !nbsy_s && cnd_s && nmsg_s) begin
                        state_d  = WAIT_REQ;
                        ino_ph_d = ino_s;
                    end
                end
                WAIT_REQ: begin
                    if (!burst) begin
                        state_d = IDLE;
                    end else if (!nreq_s) begin
                        if (!ino_ph_q && !full) begin
                            fsm_push = 1'b1;
                            state_d  = ACK;
                            hold_d   = 4'd0;
                        end else if (ino_ph_q && !empty) begin
                            fsm_pop = 1'b1;
                            state_d = ACK;
                            hold_d  = 4'd0;
                        end
                    end
                end
                ACK: begin
                    if (hold_q == HOLD_LAST) state_d = WAIT_NREQ;
                    else                     hold_d  = hold_q + 4'd1;
                end
                WAIT_NREQ: begin
                    if (nreq_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        // The handshake owns the FIFO port; a colliding host access of the same kind is dropped.
        host_push = wr0 && burst && !full && !fsm_push;
        host_pop  = rd0 && burst && !empty && !fsm_pop;
        push      = fsm_push || host_push;
        pop       = fsm_pop || host_pop;
        push_data = fsm_push ? ~ndata_s : bbc_DATA_in;
        flush     = !burst && (state_q == IDLE);
        wr_d      = flush ? '0 : wr_q + {{AW{1'b0}}, push};
        rd_d      = flush ? '0 : rd_q + {{AW{1'b0}}, pop};
        out_d     = fsm_pop ? head : out_q;
        latch_d   = (wr0 && !burst) ? bbc_DATA_in : latch_q;
        ctrl_d    = wr3 ? bbc_DATA_in[CW-1:0] : ctrl_q;

        if (wr2)         sel_d = 1'b1;
        else if (!nbsy_s) sel_d = 1'b0;
        else              sel_d = sel_q;

        if ((state_q != IDLE) || (state_d != IDLE)) ack_d = (state_d == ACK) || (state_d == WAIT_NREQ);
        else if (!burst && (rd0 || wr0))             ack_d = 1'b1;
        else if (nreq_s)                             ack_d = 1'b0;
        else                                         ack_d = ack_q;

        irq_set = ctrl_q[0] && nreq_prev_q && !nreq_s && (state_q == IDLE);
`ifdef SCSI_FIFO_IRQ_EN
        begin
            logic [PW-1:0] count_d;
            count_d = wr_d - rd_d;
            if (ctrl_q[2] && burst) begin
                if (!ino_s && (count_d == PW'(FIFO_DEPTH / 2)) && (count != PW'(FIFO_DEPTH / 2))) irq_set = 1'b1;
                if (ino_s && (count_d == '0) && !empty) irq_set = 1'b1;
            end
        end
`endif
        irq_d = wr3 ? 1'b0 : (irq_q || irq_set);
    end

    always_ff @(posedge sys_CLK) begin
        if (!bbc_nRST) begin
            sync1_q     <= SYNC_IDLE;
            sync2_q     <= SYNC_IDLE;
            e_prev_q    <= 1'b0;
            nreq_prev_q <= 1'b1;
            state_q     <= IDLE;
            hold_q      <= 4'd0;
            ino_ph_q    <= 1'b0;
            ack_q       <= 1'b0;
            sel_q       <= 1'b0;
            irq_q       <= 1'b0;
            ctrl_q      <= '0;
            latch_q     <= 8'hFF;
            out_q       <= 8'h00;
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync1_q;
            e_prev_q    <= e_s;
            nreq_prev_q <= nreq_s;
            state_q     <= state_d;
            hold_q      <= hold_d;
            ino_ph_q    <= ino_ph_d;
            ack_q       <= ack_d;
            sel_q       <= sel_d;
            irq_q       <= irq_d;
            ctrl_q      <= ctrl_d;
            latch_q     <= latch_d;
            out_q       <= out_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
        end
    end

    always_ff @(posedge sys_CLK) begin
        if (bbc_nRST && push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

    assign status = {~cnd_s, ~ino_s, ~nreq_s, irq_q, full, empty, ~nbsy_s, ~nmsg_s};

    always_comb begin
        bbc_DATA_out = 8'h00;
        if (rd_reg) begin
            case (offs)
                8'd0:    bbc_DATA_out = burst ? (empty ? 8'h00 : head) : ~ndata_s;
                8'd1:    bbc_DATA_out = status;
                8'd4:    bbc_DATA_out = {{(8 - PW){1'b0}}, count};
                default: bbc_DATA_out = 8'h00;
            endcase
        end
    end

    always_comb begin
        scsi_DATA_drv = 8'h00;
        if (ino_s) begin
            if ((state_q == ACK) || (state_q == WAIT_NREQ)) scsi_DATA_drv = out_q;
            else if (!burst && (state_q == IDLE))          scsi_DATA_drv = latch_q;
        end
    end

    assign bbc_DATA_oe  = rd_reg && e_s;
    assign bbc_IRQ_drv  = irq_q;
    assign scsi_SEL_drv = sel_q;
    assign scsi_ACK_drv = ack_q;
    assign scsi_RST_drv = ~bbc_nRST;
endmodule

// File: tb/tb_scsi_burst_adaptor.sv
// Randomised bench for scsi_burst_adaptor: host bus and SCSI target driven from tasks, checked
// against a queue-based FIFO model plus a per-cycle monitor of always-true output rules.
`timescale 1ns/1ps
module tb_scsi_burst_adaptor;
    localparam int DEPTH = 16;
    localparam int HOLD  = 3;

    logic       sys_CLK = 1'b0;
    logic       bbc_nRST = 1'b0;
    logic       bbc_1MHZE = 1'b0, bbc_nPGFC = 1'b1, bbc_RnW = 1'b1;
    logic [7:0] bbc_ADDRESS = 8'h00, bbc_DATA_in = 8'h00;
    logic [7:0] bbc_DATA_out;
    logic       bbc_DATA_oe, bbc_IRQ_drv;
    logic       scsi_nMSG = 1'b1, scsi_nBSY = 1'b1, scsi_nREQ = 1'b1, scsi_InO = 1'b0, scsi_CnD = 1'b0;
    logic [7:0] scsi_nDATA_in = 8'hFF;
    logic [7:0] scsi_DATA_drv;
    logic       scsi_SEL_drv, scsi_ACK_drv, scsi_RST_drv;

    int  checks = 0, errors = 0;
    bit  rd_active = 1'b0;
    bit  irq_m = 1'b0;
    logic [7:0] fifo_m[$];

    always #5 sys_CLK = ~sys_CLK;

    scsi_burst_adaptor #(.BASE_ADDR(8'h40), .FIFO_DEPTH(DEPTH), .ACK_HOLD(HOLD)) dut (
        .sys_CLK(sys_CLK), .bbc_nRST(bbc_nRST), .bbc_1MHZE(bbc_1MHZE), .bbc_nPGFC(bbc_nPGFC),
        .bbc_RnW(bbc_RnW), .bbc_ADDRESS(bbc_ADDRESS), .bbc_DATA_in(bbc_DATA_in),
        .bbc_DATA_out(bbc_DATA_out), .bbc_DATA_oe(bbc_DATA_oe), .bbc_IRQ_drv(bbc_IRQ_drv),
        .scsi_nMSG(scsi_nMSG), .scsi_nBSY(scsi_nBSY), .scsi_nREQ(scsi_nREQ), .scsi_InO(scsi_InO),
        .scsi_CnD(scsi_CnD), .scsi_nDATA_in(scsi_nDATA_in), .scsi_DATA_drv(scsi_DATA_drv),
        .scsi_SEL_drv(scsi_SEL_drv), .scsi_ACK_drv(scsi_ACK_drv), .scsi_RST_drv(scsi_RST_drv)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge sys_CLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] status_m();
        return {~scsi_CnD, ~scsi_InO, ~scsi_nREQ, irq_m,
                fifo_m.size() == DEPTH, fifo_m.size() == 0, ~scsi_nBSY, ~scsi_nMSG};
    endfunction

    task automatic bus(input logic rnw, input logic [7:0] off, input logic [7:0] wd, output logic [7:0] rd);
        @(negedge sys_CLK);
        bbc_nPGFC = 1'b0; bbc_ADDRESS = 8'h40 + off; bbc_RnW = rnw; bbc_DATA_in = wd;
        rd_active = rnw;
        tick(1);
        bbc_1MHZE = 1'b1;
        tick(5);
        rd = bbc_DATA_out;
        if (rnw) check($sformatf("oe_rd_off%0d", off), bbc_DATA_oe, 1);
        bbc_1MHZE = 1'b0;
        tick(5);
        bbc_nPGFC = 1'b1; bbc_RnW = 1'b1;
        tick(1);
        rd_active = 1'b0;
        tick(1);
        $display("bus %s off=%0d wd=%02h rd=%02h", rnw ? "RD" : "WR", off, wd, rd);
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] wd);
        logic [7:0] dummy;
        bus(1'b0, off, wd, dummy);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
    endtask

    task automatic tgt_byte(input logic [7:0] b, output logic [7:0] drv, output int hi);
        int n = 0;
        drv = 8'h00; hi = 0;
        scsi_nDATA_in = ~b; scsi_nREQ = 1'b0;
        while (scsi_ACK_drv !== 1'b1 && n < 40) begin
            @(negedge sys_CLK);
            n++;
        end
        check("ack_rise", scsi_ACK_drv, 1);
        if (scsi_ACK_drv === 1'b1) begin
            drv = scsi_DATA_drv; hi = 1;
            scsi_nREQ = 1'b1; scsi_nDATA_in = 8'hFF;
            for (int k = 0; k < 40; k++) begin
                @(negedge sys_CLK);
                if (scsi_ACK_drv !== 1'b1) break;
                hi++;
            end
            checks++;
            if (hi < HOLD || hi > HOLD + 4) begin
                errors++;
                $display("FAIL ack_hold: got %0d cycles, expected %0d..%0d", hi, HOLD, HOLD + 4);
            end
        end
        scsi_nREQ = 1'b1; scsi_nDATA_in = 8'hFF;
        tick(1);
        $display("tgt byte=%02h drv=%02h ack_cycles=%0d", b, drv, hi);
    endtask

    task automatic read_count(input string name);
        logic [7:0] r;
        bus(1'b1, 8'd4, 8'h00, r);
        check(name, r, fifo_m.size());
    endtask

    task automatic host_pop_check(input string name);
        logic [7:0] r, e;
        e = (fifo_m.size() == 0) ? 8'h00 : fifo_m.pop_front();
        bus(1'b1, 8'd0, 8'h00, r);
        check(name, r, e);
    endtask

    task automatic main_seq();
        logic [7:0] r, b, d;
        int hi, n, cnt;

        // Reset state, sampled while reset is held
        tick(5);
        check("rst_ack", scsi_ACK_drv, 0);
        check("rst_sel", scsi_SEL_drv, 0);
        check("rst_irq", bbc_IRQ_drv, 0);
        check("rst_drv", scsi_DATA_drv, 8'h00);
        check("rst_oe", bbc_DATA_oe, 0);
        check("rst_rstdrv", scsi_RST_drv, 1);
        bbc_nRST = 1'b1;
        tick(4);

        bus(1'b1, 8'd1, 8'h00, r);
        check("status_idle_lit", r, 8'hC4);
        check("status_idle", r, status_m());
        read_count("count_rst");

        // Legacy write with outbound phase: drive latch and ACK until REQ drops
        scsi_InO = 1'b1;
        tick(4);
        scsi_nREQ = 1'b0;
        wr(8'd0, 8'hA5);
        check("leg_wr_drv", scsi_DATA_drv, 8'hA5);
        check("leg_wr_ack", scsi_ACK_drv, 1);
        scsi_nREQ = 1'b1;
        tick(2);
        check("leg_ack_hold", scsi_ACK_drv, 1);
        tick(1);
        check("leg_ack_clr", scsi_ACK_drv, 0);

        // Legacy read of an inverted bus byte
        scsi_InO = 1'b0;
        b = 8'($urandom);
        scsi_nDATA_in = ~b;
        tick(4);
        scsi_nREQ = 1'b0;
        bus(1'b1, 8'd0, 8'h00, r);
        check("leg_rd_data", r, b);
        check("leg_rd_ack", scsi_ACK_drv, 1);
        scsi_nREQ = 1'b1; scsi_nDATA_in = 8'hFF;
        tick(4);
        check("leg_rd_ack_clr", scsi_ACK_drv, 0);

        // Selection: SEL asserted by +2 write, released once BSY seen
        wr(8'd2, 8'h00);
        check("sel_set", scsi_SEL_drv, 1);
        scsi_nBSY = 1'b0;
        tick(4);
        check("sel_clr", scsi_SEL_drv, 0);

        // REQ rising while idle with IRQEN raises IRQ; +3 write clears it
        wr(8'd3, 8'h01);
        scsi_nREQ = 1'b0;
        tick(4);
        irq_m = 1'b1;
        check("irq_set", bbc_IRQ_drv, 1);
        bus(1'b1, 8'd1, 8'h00, r);
        check("status_irq_lit", r, 8'hF6);
        check("status_irq", r, status_m());
        wr(8'd3, 8'h01);
        irq_m = 1'b0;
        check("irq_clr", bbc_IRQ_drv, 0);
        scsi_nREQ = 1'b1;
        tick(4);
        wr(8'd3, 8'h00);

        // Burst inbound 0..15 fills the FIFO
        scsi_CnD = 1'b1; scsi_nMSG = 1'b1;
        wr(8'd3, 8'h02);
        tick(3);
        for (int i = 0; i < DEPTH; i++) begin
            tgt_byte(8'(i), d, hi);
            model_push(8'(i));
        end
        bus(1'b1, 8'd4, 8'h00, r);
        check("count_full_lit", r, 8'd16);
        check("count_full", r, fifo_m.size());
        bus(1'b1, 8'd1, 8'h00, r);
        check("status_full_lit", r, 8'h4A);
        check("status_full", r, status_m());

        // 17th byte must stall with ACK low
        scsi_nDATA_in = ~8'hEE; scsi_nREQ = 1'b0;
        tick(20);
        check("full_stall", scsi_ACK_drv, 0);
        scsi_nREQ = 1'b1; scsi_nDATA_in = 8'hFF;
        tick(4);
        for (int i = 0; i < DEPTH; i++) host_pop_check($sformatf("rd_inorder_%0d", i));
        host_pop_check("rd_empty");
        read_count("count_empty");

        // Random inbound rounds with partial drains
        repeat (3) begin
            n = $urandom_range(1, DEPTH - fifo_m.size());
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                tgt_byte(b, d, hi);
                model_push(b);
            end
            read_count("count_rnd_in");
            n = $urandom_range(1, fifo_m.size());
            for (int i = 0; i < n; i++) host_pop_check("rd_rnd");
        end
        while (fifo_m.size() > 0) host_pop_check("rd_drain");

        // Outbound: host fills (17th discarded), target drains and sees driven bytes
        scsi_InO = 1'b1;
        tick(6);
        for (int i = 0; i <= DEPTH; i++) begin
            b = 8'($urandom);
            wr(8'd0, b);
            model_push(b);
        end
        read_count("count_out_full");
        n = $urandom_range(1, DEPTH);
        for (int i = 0; i < n; i++) begin
            tgt_byte(8'h00, d, hi);
            check("out_drv", d, fifo_m.pop_front());
        end
        read_count("count_out_part");
        while (fifo_m.size() > 0) host_pop_check("rd_out_drain");

        // Abort: BSY released while ACK is asserted
        scsi_InO = 1'b0;
        tick(6);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            tgt_byte(b, d, hi);
            model_push(b);
        end
        b = 8'($urandom);
        scsi_nDATA_in = ~b; scsi_nREQ = 1'b0;
        cnt = 0;
        while (scsi_ACK_drv !== 1'b1 && cnt < 40) begin tick(1); cnt++; end
        check("abort_ack_seen", scsi_ACK_drv, 1);
        model_push(b);
        scsi_nBSY = 1'b1;
        cnt = 0;
        while (scsi_ACK_drv === 1'b1 && cnt < 20) begin tick(1); cnt++; end
        check("abort_ack_latency", cnt, 3);
        scsi_nREQ = 1'b1; scsi_nDATA_in = 8'hFF;
        read_count("abort_count");
        scsi_nBSY = 1'b0;
        tick(6);

        // Clearing BURST flushes the FIFO
        wr(8'd3, 8'h00);
        fifo_m.delete();
        read_count("flush_count");

        // Reset mid-handshake drops ACK on that edge
        wr(8'd3, 8'h02);
        tick(3);
        scsi_nDATA_in = ~8'h55; scsi_nREQ = 1'b0;
        cnt = 0;
        while (scsi_ACK_drv !== 1'b1 && cnt < 40) begin tick(1); cnt++; end
        check("rstmid_ack_seen", scsi_ACK_drv, 1);
        bbc_nRST = 1'b0;
        tick(1);
        check("rstmid_ack_drop", scsi_ACK_drv, 0);
        tick(2);
        bbc_nRST = 1'b1;
        scsi_nREQ = 1'b1; scsi_nDATA_in = 8'hFF;
        fifo_m.delete();
        tick(4);
        read_count("rstmid_count");
    endtask

    initial begin
        int ino_low = 0;
        fork
            forever begin
                @(negedge sys_CLK);
                if (scsi_InO) ino_low = 0;
                else if (ino_low < 100) ino_low++;
                check("mon_rst_drv", scsi_RST_drv, !bbc_nRST);
                if (!rd_active) check("mon_oe_idle", bbc_DATA_oe, 0);
                if (ino_low >= 4) check("mon_drv_inbound", scsi_DATA_drv, 8'h00);
            end
            main_seq();
            begin
                #2ms;
                errors++;
                $display("FAIL watchdog: got timeout, expected completion");
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
